// File: rtl/relay_pkg.sv
// Shared relay link definitions: FSM state encodings, bit timing and start-bit polarity.
// RELAY_ENCODE_PARITY_EN adds the PARITY state encoding.
package relay_pkg;

    localparam int unsigned RELAY_BIT_CYCLES = 64;

    // Polarity of the frame start slot, shared with the relay decoder.
    localparam logic RELAY_START_BIT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef RELAY_ENCODE_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_GUARD  = 3'd4
    } relay_state_t;

endpackage

// File: rtl/relay_bit_timer.sv
// Bit-slot timer for the relay encoder: counts 0..BIT_CYCLES-1 and strobes slot_end
// on the last clock of each slot.
module relay_bit_timer
    import relay_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = RELAY_BIT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic slot_end
);

    localparam int unsigned CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] bit_cnt;

    assign slot_end = enable && (bit_cnt == CNT_LAST);

    // Held at zero while idle so the first slot after a load is full length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
        end else if (clear || !enable || slot_end) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/relay_encode.sv
// Relay link serial transmitter: start slot, data slots, optional parity slot, guard time.
// Define RELAY_ENCODE_PARITY_EN to insert an even-parity slot after the data bits.
module relay_encode
    import relay_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = RELAY_BIT_CYCLES,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned GUARD_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 data_out,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned IDX_W  = (DATA_BITS  > 1) ? $clog2(DATA_BITS)  : 1;
    localparam int unsigned GIDX_W = (GUARD_BITS > 1) ? $clog2(GUARD_BITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [GIDX_W-1:0] GIDX_LAST = GIDX_W'(GUARD_BITS - 1);

    relay_state_t state, state_next;

    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_mode;
    logic                 hold_full;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 cur_mode, mode_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [GIDX_W-1:0]    guard_idx, guard_idx_next;
    logic                 load;
    logic                 accept;
    logic                 slot_end;
    logic                 data_out_next;
`ifdef RELAY_ENCODE_PARITY_EN
    logic                 par_bit, par_next;
`endif

    assign tx_ready   = !hold_full;
    assign accept     = tx_valid && !hold_full;
    assign busy       = (state != ST_IDLE);
    assign frame_done = (state == ST_GUARD) && slot_end && (guard_idx == GIDX_LAST);

    relay_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (load),
        .enable  (state != ST_IDLE),
        .slot_end(slot_end)
    );

    // accept needs hold_full=0 and load needs hold_full=1, so they never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_mode <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= tx_data;
            hold_mode <= mode;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift     <= '0;
            cur_mode  <= 1'b0;
            bit_idx   <= '0;
            guard_idx <= '0;
            data_out  <= 1'b0;
`ifdef RELAY_ENCODE_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            shift     <= shift_next;
            cur_mode  <= mode_next;
            bit_idx   <= bit_idx_next;
            guard_idx <= guard_idx_next;
            data_out  <= data_out_next;
`ifdef RELAY_ENCODE_PARITY_EN
            par_bit   <= par_next;
`endif
        end
    end

    always_comb begin
        state_next     = state;
        shift_next     = shift;
        mode_next      = cur_mode;
        bit_idx_next   = bit_idx;
        guard_idx_next = guard_idx;
        load           = 1'b0;
`ifdef RELAY_ENCODE_PARITY_EN
        par_next       = par_bit;
`endif

        unique case (state)
            ST_IDLE: begin
                if (hold_full) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (slot_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (slot_end) begin
                    if (bit_idx == IDX_LAST) begin
                        guard_idx_next = '0;
`ifdef RELAY_ENCODE_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_GUARD;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        shift_next   = cur_mode ? (shift >> 1) : (shift << 1);
                    end
                end
            end
`ifdef RELAY_ENCODE_PARITY_EN
            ST_PARITY: begin
                if (slot_end) begin
                    state_next = ST_GUARD;
                end
            end
`endif
            ST_GUARD: begin
                if (slot_end) begin
                    if (guard_idx == GIDX_LAST) begin
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        guard_idx_next = guard_idx + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A load from IDLE or from the last guard clock both start a fresh frame.
        if (load) begin
            state_next     = ST_START;
            shift_next     = hold_data;
            mode_next      = hold_mode;
            bit_idx_next   = '0;
            guard_idx_next = '0;
`ifdef RELAY_ENCODE_PARITY_EN
            par_next       = ^hold_data;
`endif
        end
    end

    // The line is registered from next-state values so it lines up with the state it describes.
    always_comb begin
        data_out_next = 1'b0;
        unique case (state_next)
            ST_START:  data_out_next = RELAY_START_BIT;
            ST_DATA:   data_out_next = mode_next ? shift_next[0] : shift_next[DATA_BITS-1];
`ifdef RELAY_ENCODE_PARITY_EN
            ST_PARITY: data_out_next = par_next;
`endif
            default:   data_out_next = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_relay_encode.sv
// Scoreboard bench for relay_encode: directed bytes push expected slot sequences,
// a negedge monitor pops them and checks every clock of each frame.
module tb_relay_encode;

    localparam int unsigned BC = 64;
`ifdef RELAY_ENCODE_PARITY_EN
    localparam int unsigned NPAR = 1;
`else
    localparam int unsigned NPAR = 0;
`endif
    localparam int unsigned NSLOT = 1 + 8 + NPAR + 1;
    localparam int unsigned FL    = NSLOT * BC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready, data_out, busy, frame_done;

    relay_encode #(
        .BIT_CYCLES(BC),
        .DATA_BITS (8),
        .GUARD_BITS(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .data_out  (data_out),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  seq;      // data slots in transmission order, first sent = bit 7
        logic        par;
        logic        b2b;      // must start with no idle cycle after the previous frame
        logic        chk_lat;  // must start exactly two clocks after its accept
        int unsigned acc;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic        mon_off = 1'b0;
    logic        in_frame = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    exp_t             cur;
    logic [NSLOT-1:0] slots;
    int unsigned      pos = 0;
    int unsigned      gap = 1000;
    logic             slot_bad, fd_bad, busy_bad, slot_got;

    always @(negedge clk) begin
        if (reset || mon_off) begin
            in_frame = 1'b0;
            gap      = 1000;
        end else begin
            if (!in_frame) begin
                if (data_out === 1'b1) begin
                    if (q.size() == 0) begin
                        check("unexpected_frame_start", 32'(data_out), 0);
                    end else begin
                        cur = q.pop_front();
                        slots = '0;
                        slots[0] = 1'b1;
                        for (int i = 0; i < 8; i++) slots[1+i] = cur.seq[7-i];
                        if (NPAR == 1) slots[9] = cur.par;
                        if (cur.b2b) check("b2b_gap", gap, 0);
                        if (cur.chk_lat) check("start_latency", cyc, cur.acc + 1);
                        in_frame = 1'b1;
                        pos      = 0;
                        slot_bad = 1'b0;
                        fd_bad   = 1'b0;
                        busy_bad = 1'b0;
                        slot_got = 1'b0;
                    end
                end else begin
                    gap++;
                end
            end
            if (in_frame) begin
                if (data_out !== slots[pos/BC] && !slot_bad) begin
                    slot_bad = 1'b1;
                    slot_got = data_out;
                end
                if (frame_done !== (pos == FL - 1)) fd_bad = 1'b1;
                if (busy !== 1'b1) busy_bad = 1'b1;
                if (pos % BC == BC - 1) begin
                    check($sformatf("slot%0d_seq%02h", pos / BC, cur.seq),
                          32'(slot_bad ? slot_got : slots[pos/BC]), 32'(slots[pos/BC]));
                    slot_bad = 1'b0;
                end
                if (pos == FL - 1) begin
                    check($sformatf("frame_done_timing_seq%02h", cur.seq), 32'(fd_bad), 0);
                    check($sformatf("busy_in_frame_seq%02h", cur.seq), 32'(busy_bad), 0);
                    in_frame = 1'b0;
                    gap      = 0;
                end
                pos++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [7:0] d, input logic m, input logic [7:0] seq,
                        input logic par, input logic b2b, input logic lat, input logic push);
        int unsigned n = 0;
        exp_t e;
        tx_data  = d;
        mode     = m;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            check("accept_timeout", 32'(tx_ready), 1);
        end else if (push) begin
            e.seq = seq; e.par = par; e.b2b = b2b; e.chk_lat = lat; e.acc = cyc + 1;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int unsigned n = 0;
        tx_valid = 1'b0;
        while ((q.size() != 0 || in_frame) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("drain_timeout", q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int unsigned n;
        logic bad_do, bad_busy, bad_rdy, bad_fd;
        int unsigned rdy_high;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data_out", 32'(data_out), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_tx_ready", 32'(tx_ready), 1);
        check("reset_frame_done", 32'(frame_done), 0);
        reset = 1'b0;

        bad_do = 0; bad_busy = 0; bad_rdy = 0;
        repeat (1000) begin
            @(negedge clk);
            if (data_out !== 1'b0) bad_do = 1;
            if (busy !== 1'b0) bad_busy = 1;
            if (tx_ready !== 1'b1) bad_rdy = 1;
        end
        check("idle_data_out_stuck", 32'(bad_do), 0);
        check("idle_busy_stuck", 32'(bad_busy), 0);
        check("idle_tx_ready_stuck", 32'(bad_rdy), 0);

        // Single frames: data, mode, hand-derived transmission order, even parity.
        send(8'hA5, 1'b0, 8'b10100101, 1'b0, 1'b0, 1'b1, 1'b1); drain();
        send(8'h01, 1'b1, 8'b10000000, 1'b1, 1'b0, 1'b1, 1'b1); drain();
        send(8'h35, 1'b1, 8'b10101100, 1'b0, 1'b0, 1'b1, 1'b1); drain();
        send(8'h80, 1'b1, 8'b00000001, 1'b1, 1'b0, 1'b1, 1'b1); drain();
        send(8'hFF, 1'b0, 8'b11111111, 1'b0, 1'b0, 1'b1, 1'b1); drain();
`ifdef RELAY_ENCODE_PARITY_EN
        send(8'h07, 1'b0, 8'b00000111, 1'b1, 1'b0, 1'b1, 1'b1); drain();
        send(8'h03, 1'b1, 8'b11000000, 1'b0, 1'b0, 1'b1, 1'b1); drain();
`endif

        // Back-to-back: second byte queued during frame one.
        send(8'hA5, 1'b0, 8'b10100101, 1'b0, 1'b0, 1'b1, 1'b1);
        send(8'h3C, 1'b0, 8'b00111100, 1'b0, 1'b1, 1'b0, 1'b1);
        tx_valid = 1'b0;
        check("b2b_ready_low_after_queue", 32'(tx_ready), 0);
        n = 0; rdy_high = 0;
        while (frame_done !== 1'b1 && n < 2000) begin
            if (tx_ready !== 1'b0) rdy_high++;
            @(negedge clk);
            n++;
        end
        check("b2b_frame_one_done_seen", 32'(frame_done), 1);
        check("b2b_ready_high_cycles", rdy_high, 0);
        @(negedge clk);
        check("b2b_ready_after_load", 32'(tx_ready), 1);
        drain();

        // Abort: reset at cycle 300 of a frame with a byte queued.
        mon_off = 1'b1;
        send(8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tx_valid = 1'b0;
        n = 0;
        while (data_out !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_frame_started", 32'(data_out), 1);
        send(8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tx_valid = 1'b0;
        repeat (298) @(negedge clk);
        check("abort_queued_ready_low", 32'(tx_ready), 0);
        check("abort_busy_before", 32'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check("abort_data_out", 32'(data_out), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_tx_ready", 32'(tx_ready), 1);
        check("abort_frame_done", 32'(frame_done), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad_do = 0; bad_fd = 0; bad_busy = 0;
        repeat (800) begin
            @(negedge clk);
            if (data_out !== 1'b0) bad_do = 1;
            if (frame_done !== 1'b0) bad_fd = 1;
            if (busy !== 1'b0) bad_busy = 1;
        end
        check("abort_queued_byte_lost", 32'(bad_do), 0);
        check("abort_no_frame_done", 32'(bad_fd), 0);
        check("abort_stays_idle", 32'(bad_busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
